// File: rtl/ucie_ctl_rx_link_ctrl.sv
// RX link controller: sequences the adapter RX buffer and FDI output through
// RESET / ACTIVE / RETRAIN / LINKERROR, draining the buffer before leaving ACTIVE.
module ucie_ctl_rx_link_ctrl #(
    parameter int unsigned ENTRY_DELAY   = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_state_req,
    input  logic       i_state_req_valid,
    input  logic       i_overflow_detected,
    input  logic       i_buffer_empty,
    output logic       o_buffer_enable,
    output logic       o_buffer_flush,
    output logic [1:0] o_state_status,
    output logic       o_busy,
    output logic       o_state_ack,
    output logic       o_req_reject,
    output logic       o_linkerror,
    output logic       o_overflow_detected
);

    localparam logic [1:0] REQ_NOP       = 2'd0;
    localparam logic [1:0] REQ_ACTIVE    = 2'd1;
    localparam logic [1:0] REQ_RETRAIN   = 2'd2;
    localparam logic [1:0] REQ_LINKRESET = 2'd3;

    localparam logic [1:0] ST_RESET     = 2'd0;
    localparam logic [1:0] ST_ACTIVE    = 2'd1;
    localparam logic [1:0] ST_RETRAIN   = 2'd2;
    localparam logic [1:0] ST_LINKERROR = 2'd3;

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_ENTRY,
        S_ACTIVE,
        S_DRAIN,
        S_RETRAIN,
        S_LINKERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tgt_retrain;
    logic             tgt_nxt;
    logic             req;
    logic             ack_nxt;
    logic             rej_nxt;
    logic             enable_nxt;
    logic             flush_nxt;
    logic [1:0]       status_nxt;
    logic             busy_nxt;
    logic             linkerror_nxt;
    logic             ovf_nxt;

    // A NOP with valid set is not a request at all.
    assign req = i_state_req_valid && (i_state_req != REQ_NOP);

    // State, shared down-counter and latched drain target.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_RESET;
            cnt         <= '0;
            tgt_retrain <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tgt_retrain <= tgt_nxt;
        end
    end

    // Next-state, counter and handshake pulse decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt_retrain;
        ack_nxt   = 1'b0;
        rej_nxt   = 1'b0;
        case (state)
            S_RESET: begin
                if (req) begin
                    case (i_state_req)
                        REQ_ACTIVE: begin
                            state_nxt = S_ENTRY;
                            cnt_nxt   = ENTRY_LOAD;
                        end
                        REQ_LINKRESET: ack_nxt = 1'b1;
                        default:       rej_nxt = 1'b1;
                    endcase
                end
            end
            S_ENTRY: begin
                rej_nxt = req;
                if (cnt == '0) begin
                    state_nxt = S_ACTIVE;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (i_overflow_detected) begin
                    state_nxt = S_LINKERROR;
                    ack_nxt   = 1'b1;
                    rej_nxt   = req;
                end else if (req) begin
                    if (i_state_req == REQ_ACTIVE) begin
                        ack_nxt = 1'b1;
                    end else begin
                        state_nxt = S_DRAIN;
                        tgt_nxt   = (i_state_req == REQ_RETRAIN);
                        cnt_nxt   = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                rej_nxt = req;
                if (i_overflow_detected) begin
                    state_nxt = S_LINKERROR;
                    ack_nxt   = 1'b1;
                end else if (i_buffer_empty) begin
                    state_nxt = tgt_retrain ? S_RETRAIN : S_RESET;
                    ack_nxt   = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = S_LINKERROR;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RETRAIN: begin
                if (req) begin
                    case (i_state_req)
                        REQ_ACTIVE: begin
                            state_nxt = S_ENTRY;
                            cnt_nxt   = ENTRY_LOAD;
                        end
                        REQ_RETRAIN: ack_nxt = 1'b1;
                        default: begin
                            state_nxt = S_RESET;
                            ack_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_LINKERROR: begin
                if (req) begin
                    if (i_state_req == REQ_LINKRESET) begin
                        state_nxt = S_RESET;
                        ack_nxt   = 1'b1;
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_RESET;
        endcase
    end

    // Output values for the cycle after the transition, decoded from next state.
    always_comb begin
        enable_nxt    = 1'b0;
        flush_nxt     = 1'b0;
        status_nxt    = o_state_status;
        busy_nxt      = 1'b0;
        linkerror_nxt = 1'b0;
        ovf_nxt       = o_overflow_detected | i_overflow_detected;
        if ((state == S_LINKERROR) && (state_nxt == S_RESET)) begin
            ovf_nxt = 1'b0;
        end
        case (state_nxt)
            S_RESET: begin
                flush_nxt  = 1'b1;
                status_nxt = ST_RESET;
            end
            S_ENTRY, S_DRAIN: busy_nxt = 1'b1;
            S_ACTIVE: begin
                enable_nxt = 1'b1;
                status_nxt = ST_ACTIVE;
            end
            S_RETRAIN: status_nxt = ST_RETRAIN;
            S_LINKERROR: begin
                flush_nxt     = 1'b1;
                linkerror_nxt = 1'b1;
                status_nxt    = ST_LINKERROR;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_buffer_enable     <= 1'b0;
            o_buffer_flush      <= 1'b1;
            o_state_status      <= ST_RESET;
            o_busy              <= 1'b0;
            o_state_ack         <= 1'b0;
            o_req_reject        <= 1'b0;
            o_linkerror         <= 1'b0;
            o_overflow_detected <= 1'b0;
        end else begin
            o_buffer_enable     <= enable_nxt;
            o_buffer_flush      <= flush_nxt;
            o_state_status      <= status_nxt;
            o_busy              <= busy_nxt;
            o_state_ack         <= ack_nxt;
            o_req_reject        <= rej_nxt;
            o_linkerror         <= linkerror_nxt;
            o_overflow_detected <= ovf_nxt;
        end
    end

endmodule

// File: doc/ucie_ctl_rx_link_ctrl.md
Name: ucie_ctl_rx_link_ctrl

Overview:
- Sequences the adapter RX datapath (RX buffer plus FDI output) through the link states RESET, ACTIVE, RETRAIN and LINKERROR.
- Accepts state requests from the adapter state handler with a valid/ack handshake.
- Drives buffer enable/flush, drains the buffer before leaving ACTIVE, and escalates buffer overflow or drain timeout to LINKERROR.
- Sits beside the RX buffer and replaces ad-hoc enable control.

Parameters:
- ENTRY_DELAY, 4, cycles spent in ENTRY before ACTIVE is declared (valid range 1..2^CNT_W).
- DRAIN_TIMEOUT, 64, maximum cycles in DRAIN waiting for buffer empty (valid range 1..2^CNT_W).
- CNT_W, 8, width of the shared down-counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_state_req  in  2  request code: 00 NOP, 01 ACTIVE, 10 RETRAIN, 11 LINKRESET
- i_state_req_valid  in  1  request strobe; one-cycle pulse
- i_overflow_detected  in  1  overflow pulse from the RX buffer
- i_buffer_empty  in  1  RX buffer holds no data
- o_buffer_enable  out  1  RX buffer write/read enable
- o_buffer_flush  out  1  RX buffer pointer clear
- o_state_status  out  2  stable state: 0 RESET, 1 ACTIVE, 2 RETRAIN, 3 LINKERROR
- o_busy  out  1  FSM is in ENTRY or DRAIN
- o_state_ack  out  1  one-cycle pulse when a request completes
- o_req_reject  out  1  one-cycle pulse when a request is ignored
- o_linkerror  out  1  high while in LINKERROR
- o_overflow_detected  out  1  sticky overflow flag

Behaviour:
- All outputs are registered.
- Reset values: state RESET, o_buffer_enable 0, o_buffer_flush 1, o_state_status 0, o_busy 0, o_state_ack 0, o_req_reject 0, o_linkerror 0, o_overflow_detected 0, counter 0. i_rst overrides everything, including mid-DRAIN or mid-ENTRY.
- Six internal states: RESET, ENTRY, ACTIVE, DRAIN, RETRAIN, LINKERROR.
- o_state_status changes only on arrival in a stable state. During ENTRY and DRAIN it holds the prior stable value and o_busy is 1.
- o_state_ack pulses in the first cycle the new stable state is visible on o_state_status. A request for the current stable state acks in the next cycle with no transition.
- RESET: enable 0, flush 1.
  - ACTIVE request -> ENTRY; counter loads ENTRY_DELAY-1.
  - RETRAIN request -> reject.
  - LINKRESET request -> ack.
- ENTRY: enable 0, flush 0; counter decrements each cycle. At counter 0 -> ACTIVE. ACTIVE is visible exactly ENTRY_DELAY+1 cycles after the request cycle.
- ACTIVE: enable 1, flush 0.
  - i_overflow_detected -> LINKERROR. Overflow has priority over a same-cycle request; that request is rejected.
  - RETRAIN or LINKRESET request -> DRAIN; target is latched; counter loads DRAIN_TIMEOUT-1.
- DRAIN: enable 0, flush 0. Exit conditions are evaluated in priority order:
  - overflow -> LINKERROR;
  - i_buffer_empty -> latched target (RETRAIN, or RESET for LINKRESET);
  - counter 0 with buffer not empty -> LINKERROR (timeout).
  - Otherwise the counter decrements.
  - Empty in the first DRAIN cycle exits after 1 cycle.
- RETRAIN: enable 0, flush 0.
  - ACTIVE request -> ENTRY.
  - LINKRESET request -> RESET. No drain is needed because the buffer is disabled.
- LINKERROR: enable 0, flush 1, o_linkerror 1.
  - Only a LINKRESET request exits, to RESET; o_overflow_detected clears on that transition.
  - All other requests are rejected.
- Any request (non-NOP with valid) arriving during ENTRY or DRAIN pulses o_req_reject and is discarded.
- A NOP with valid set is ignored and produces no pulse.
- Every entry into LINKERROR acks, whether or not a request caused it.
- o_overflow_detected sets on i_overflow_detected in any state. It clears only on LINKERROR->RESET or on i_rst.
- Counter arithmetic: unsigned CNT_W bits, never wraps. It is loaded on entry and decremented only while above 0.

Test Plan:
- Reset, then ACTIVE request at cycle 0 (ENTRY_DELAY=4) -> o_busy high cycles 1-4; cycle 5: status=1, ack pulse, enable=1.
- In ACTIVE, RETRAIN request with i_buffer_empty=0 for 10 cycles, then 1 -> enable drops next cycle; status=2 with ack once empty is seen; no linkerror.
- In ACTIVE, LINKRESET request with empty never asserted (DRAIN_TIMEOUT=64) -> LINKERROR at 64 cycles after DRAIN entry; status=3, o_linkerror=1, flush=1.
- In ACTIVE, overflow pulse and RETRAIN request in the same cycle -> LINKERROR, o_req_reject pulse, o_overflow_detected sticky high; a later LINKRESET request -> RESET, sticky flag cleared.
- ACTIVE request issued during ENTRY, and RETRAIN request issued in RESET -> o_req_reject pulses, state sequence unchanged.
- i_rst asserted mid-DRAIN -> next cycle all outputs at reset values, status=0.
